// File: rtl/bow_pkg.sv
// rtl/bow_pkg.sv - shared constants, state encoding and entry layout for the BoW transmitter
package bow_pkg;

    localparam logic [15:0] SYNC_WORD  = 16'h7FFE;
    localparam logic [15:0] TRAIN_WORD = 16'hAAAA;
    localparam int          BURST_LEN  = 32;
    localparam int          TRAIN_LEN  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        TRAIN = 3'd2,
        SYNC  = 3'd3,
        SEND  = 3'd4
    } state_t;

    typedef struct packed {
        logic [15:0] data;
        logic        fec;
        logic        aux;
    } entry_t;

endpackage

// File: rtl/bow_tx_buf.sv
// rtl/bow_tx_buf.sv - 32x18 burst buffer, one write port and one registered read port
module bow_tx_buf
    import bow_pkg::*;
(
    input  logic   clk_pos,
    input  logic   wr_en,
    input  logic [4:0] wr_addr,
    input  entry_t wr_entry,
    input  logic [4:0] rd_addr,
    output entry_t rd_entry
);

    entry_t mem [BURST_LEN];

    always_ff @(posedge clk_pos) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_entry;
        end
        rd_entry <= mem[rd_addr];
    end

endmodule

// File: rtl/bow_tx.sv
// rtl/bow_tx.sv - BoW burst transmitter: APB fill, training, sync word, 32-word burst
module bow_tx
    import bow_pkg::*;
(
    input  logic        clk_pos,
    input  logic        presetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [15:0] pwdata,
    input  logic        pfec,
    input  logic        paux,
    output logic        pready,
    output logic [15:0] prdata,
    input  logic        tx_ready,
    output logic [15:0] tx_data,
    output logic        tx_fec,
    output logic        tx_aux,
    output logic        tx_valid
);

    state_t     state, next_state;
    logic [5:0] wr_cnt;
    logic [4:0] rd_ptr;
    logic [4:0] rd_addr;
    logic [2:0] train_cnt;
    logic       can_write, wr_en, burst_done, train_done;
    entry_t     wr_entry, rd_entry;

    assign can_write  = ((state == IDLE) || (state == FILL)) && (wr_cnt < 6'(BURST_LEN));
    assign pready     = !pwrite || can_write;
    assign wr_en      = psel && penable && pwrite && can_write;
    assign prdata     = {10'b0, wr_cnt};
    assign burst_done = (state == SEND) && (rd_ptr == 5'(BURST_LEN - 1));
    assign train_done = (train_cnt == 3'(TRAIN_LEN - 1));
    assign wr_entry   = {pwdata, pfec, paux};

    // Read data is registered twice (buffer, then lanes), so the address runs two entries ahead.
    always_comb begin
        rd_addr = 5'd0;
        if (state == SYNC) begin
            rd_addr = 5'd1;
        end else if (state == SEND) begin
            rd_addr = rd_ptr + 5'd2;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (wr_en) next_state = FILL;
            FILL:    if (wr_en && (wr_cnt == 6'(BURST_LEN - 1))) next_state = TRAIN;
            TRAIN:   if (train_done && tx_ready) next_state = SYNC;
            SYNC:    next_state = SEND;
            SEND:    if (burst_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_pos or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk_pos or negedge presetn) begin
        if (!presetn) begin
            wr_cnt    <= 6'd0;
            rd_ptr    <= 5'd0;
            train_cnt <= 3'd0;
            tx_data   <= 16'd0;
            tx_fec    <= 1'b0;
            tx_aux    <= 1'b0;
            tx_valid  <= 1'b0;
        end else begin
            if (burst_done) begin
                wr_cnt <= 6'd0;
            end else if (wr_en) begin
                wr_cnt <= wr_cnt + 6'd1;
            end

            if (state != TRAIN) begin
                train_cnt <= 3'd0;
            end else if (!train_done) begin
                train_cnt <= train_cnt + 3'd1;
            end

            rd_ptr <= (state == SEND) ? rd_ptr + 5'd1 : 5'd0;

            // Lanes are driven from the upcoming state so they line up with it cycle for cycle.
            case (next_state)
                TRAIN: {tx_data, tx_fec, tx_aux, tx_valid} <= {TRAIN_WORD, 3'b000};
                SYNC:  {tx_data, tx_fec, tx_aux, tx_valid} <= {SYNC_WORD, 3'b001};
                SEND:  {tx_data, tx_fec, tx_aux, tx_valid} <= {rd_entry.data, rd_entry.fec, rd_entry.aux, 1'b1};
                default: {tx_data, tx_fec, tx_aux, tx_valid} <= 19'd0;
            endcase
        end
    end

    bow_tx_buf u_buf (
        .clk_pos  (clk_pos),
        .wr_en    (wr_en),
        .wr_addr  (wr_cnt[4:0]),
        .wr_entry (wr_entry),
        .rd_addr  (rd_addr),
        .rd_entry (rd_entry)
    );

endmodule

// File: tb/tb_bow_tx.sv
// tb/tb_bow_tx.sv - scoreboard bench for bow_tx
module tb_bow_tx;

    logic        clk_pos = 1'b0;
    logic        presetn;
    logic        psel, penable, pwrite;
    logic [15:0] pwdata;
    logic        pfec, paux;
    logic        pready;
    logic [15:0] prdata;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic        tx_fec, tx_aux, tx_valid;

    int errors = 0;
    int checks = 0;
    int mcount = 0;
    logic [17:0] sb[$];

    always #5 clk_pos = ~clk_pos;

    bow_tx dut (
        .clk_pos  (clk_pos),
        .presetn  (presetn),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pfec     (pfec),
        .paux     (paux),
        .pready   (pready),
        .prdata   (prdata),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_fec   (tx_fec),
        .tx_aux   (tx_aux),
        .tx_valid (tx_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every valid lane word must be the next scoreboard entry.
    initial begin
        logic [17:0] exp_word;
        forever begin
            @(negedge clk_pos);
            if (presetn && tx_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h with empty scoreboard", {tx_data, tx_fec, tx_aux});
                end else begin
                    exp_word = sb.pop_front();
                    check("lane_word", {14'b0, tx_data, tx_fec, tx_aux}, {14'b0, exp_word});
                end
            end
        end
    end

    task automatic apb_write(input logic [15:0] d, input logic f, input logic a,
                             output int waits, output logic prev_valid);
        if (mcount == 0) sb.push_back({16'h7FFE, 2'b00});
        sb.push_back({d, f, a});
        mcount = (mcount == 31) ? 0 : mcount + 1;
        @(posedge clk_pos); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; pwdata = d; pfec = f; paux = a;
        @(posedge clk_pos); #1;
        penable = 1'b1;
        waits = 0;
        prev_valid = 1'b0;
        @(negedge clk_pos);
        while (!pready && waits < 100) begin
            prev_valid = tx_valid;
            @(negedge clk_pos);
            waits++;
        end
        check("write_accept", {31'b0, pready}, 32'd1);
        @(posedge clk_pos); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(output logic [15:0] data, output logic rdy);
        @(posedge clk_pos); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk_pos); #1;
        penable = 1'b1;
        @(negedge clk_pos);
        data = prdata;
        rdy = pready;
        @(posedge clk_pos); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic observe(input int exp_train, input int release_at);
        int run, nval, n;
        run = 0; n = 0; nval = 0;
        @(negedge clk_pos);
        while (!tx_valid && n < 300) begin
            if (tx_data == 16'hAAAA) run++;
            if (release_at > 0 && run == release_at) tx_ready = 1'b1;
            @(negedge clk_pos);
            n++;
        end
        check("train_len", run, exp_train);
        check("sync_word", {13'b0, tx_fec, tx_aux, tx_valid, tx_data}, {16'h0001, 16'h7FFE});
        while (tx_valid && nval < 100) begin
            nval++;
            @(negedge clk_pos);
        end
        check("burst_valid_cycles", nval, 33);
        check("idle_lanes", {13'b0, tx_fec, tx_aux, tx_valid, tx_data}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w, n, nval;
        logic pv, rdy;
        logic [15:0] rd;

        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pwdata = 16'd0; pfec = 1'b0; paux = 1'b0; tx_ready = 1'b1;
        @(negedge clk_pos);
        check("reset_lanes", {13'b0, tx_fec, tx_aux, tx_valid, tx_data}, 32'd0);
        check("reset_prdata", {16'b0, prdata}, 32'd0);
        @(negedge clk_pos);
        presetn = 1'b1;

        // Basic burst: counting data, fec=i[0], aux=i[1].
        for (int i = 0; i < 32; i++) apb_write(16'(i), i[0], i[1], w, pv);
        observe(8, 0);
        apb_read(rd, rdy);
        check("status_after_burst", {16'b0, rd}, 32'd0);

        // Status mid-fill, then training held by tx_ready low.
        for (int i = 0; i < 5; i++) apb_write(16'h0100 + 16'(i), 1'b1, 1'b0, w, pv);
        apb_read(rd, rdy);
        check("status_5_writes", {16'b0, rd}, 32'd5);
        check("read_pready", {31'b0, rdy}, 32'd1);
        tx_ready = 1'b0;
        for (int i = 5; i < 32; i++) apb_write(16'h0100 + 16'(i), 1'b0, 1'b1, w, pv);
        apb_read(rd, rdy);
        check("status_full", {16'b0, rd}, 32'd32);
        observe(20, 20);
        apb_read(rd, rdy);
        check("status_after_held", {16'b0, rd}, 32'd0);

        // 33rd write stalls through TRAIN/SYNC/SEND and lands as entry 0 of the next burst.
        for (int i = 0; i < 32; i++) apb_write(16'h0200 + 16'(i), ~i[0], i[0], w, pv);
        fork
            observe(8, 0);
            apb_write(16'h0BAD, 1'b1, 1'b0, w, pv);
        join
        check("stall_cycles_ge33", {31'b0, (w >= 33)}, 32'd1);
        check("stall_through_last_send", {31'b0, pv}, 32'd1);
        apb_read(rd, rdy);
        check("status_after_stall", {16'b0, rd}, 32'd1);
        for (int i = 1; i < 32; i++) begin
            if (i == 3) apb_write(16'h7FFE, 1'b1, 1'b1, w, pv);
            else apb_write(16'h0300 + 16'(i), i[1], i[0], w, pv);
        end
        observe(8, 0);

        // Reset in the middle of SEND.
        for (int i = 0; i < 32; i++) apb_write(16'h1000 + 16'(i), i[0], 1'b0, w, pv);
        n = 0; nval = 0;
        while (nval < 12 && n < 300) begin
            @(negedge clk_pos);
            n++;
            if (tx_valid) nval++;
        end
        check("entry10_before_reset", {16'b0, tx_data}, 32'h100A);
        #2 presetn = 1'b0;
        #1;
        check("async_reset_lanes", {13'b0, tx_fec, tx_aux, tx_valid, tx_data}, 32'd0);
        check("async_reset_count", {16'b0, prdata}, 32'd0);
        sb.delete();
        mcount = 0;
        @(negedge clk_pos);
        @(negedge clk_pos);
        presetn = 1'b1;
        apb_read(rd, rdy);
        check("status_after_reset", {16'b0, rd}, 32'd0);
        for (int i = 0; i < 32; i++) apb_write(16'h2000 + 16'(i), ~i[0], i[0], w, pv);
        observe(8, 0);

        repeat (3) @(negedge clk_pos);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bow_tx.md
BOW_TX -- requirements
Module: bow_tx

Interface
REQ-001 clk_pos  in  1  single clock; all state updates on its rising edge.
REQ-002 presetn  in  1  reset, asynchronous, active-low.
REQ-003 psel  in  1  APB select from link layer.
REQ-004 penable  in  1  APB access phase.
REQ-005 pwrite  in  1  1 = write to burst buffer, 0 = status read.
REQ-006 pwdata  in  16  payload word.
REQ-007 pfec  in  1  FEC sideband bit, written with pwdata.
REQ-008 paux  in  1  AUX sideband bit, written with pwdata.
REQ-009 pready  out  1  APB ready; low inserts wait states.
REQ-010 prdata  out  16  status: {10'b0, wr_cnt[5:0]}.
REQ-011 tx_ready  in  1  downstream receiver ready.
REQ-012 tx_data  out  16  BoW lane data, registered.
REQ-013 tx_fec  out  1  FEC lane, registered.
REQ-014 tx_aux  out  1  AUX lane, registered.
REQ-015 tx_valid  out  1  high while the sync word or a payload word is on the lanes.

Function
REQ-016 The block SHALL use states IDLE, FILL, TRAIN, SYNC and SEND.
REQ-017 IDLE/FILL SHALL accept writes: access cycle (psel & penable & pwrite) with pready=1 stores {pwdata,pfec,paux} at wr_cnt, then wr_cnt+1; IDLE->FILL on first write.
REQ-018 pready SHALL be combinational high in any access cycle while state is IDLE/FILL and wr_cnt<32, and low for writes otherwise (wait states until back in IDLE).
REQ-019 Reads (pwrite=0) SHALL complete with pready=1 in any state; prdata valid in that cycle.
REQ-020 The cycle after the 32nd write is accepted, the block SHALL be in TRAIN; no further writes accepted.
REQ-021 TRAIN SHALL drive tx_data=16'hAAAA, fec/aux=0, tx_valid=0 for at least 8 cycles (3-bit counter), and remain in TRAIN until tx_ready=1 after the 8th cycle.
REQ-022 SYNC SHALL last exactly 1 cycle: tx_data=16'h7FFE, fec/aux=0, tx_valid=1.
REQ-023 SEND SHALL drive entries 0..31 on 32 consecutive cycles, tx_valid=1, with rd_ptr 0->31; tx_ready is ignored in SEND.
REQ-024 After entry 31, the block SHALL return to IDLE, clear wr_cnt to 0, and drive tx_data=0, fec/aux=0, tx_valid=0.
REQ-025 Payload equal to 16'h7FFE SHALL be sent unmodified; no escaping.
REQ-026 wr_cnt SHALL be 6 bits, saturate at 32, and never wrap.
REQ-027 A write access in the same cycle as the SEND->IDLE transition SHALL see pready=0 and be accepted in the following cycle.

Reset
REQ-028 presetn=0 SHALL immediately force state IDLE, wr_cnt=0, rd_ptr=0, training count=0, tx_data=0, tx_fec=0, tx_aux=0, tx_valid=0.
REQ-029 Reset mid-burst SHALL abandon the burst; buffer contents are don't-care but are never transmitted.

Structure
REQ-030 Package bow_pkg SHALL hold SYNC_WORD=16'h7FFE, TRAIN_WORD=16'hAAAA, BURST_LEN=32, TRAIN_LEN=8 and the state encoding.
REQ-031 The 32x18 storage SHALL be the sub-module bow_tx_buf: one write port and one synchronous read port, not reset.
REQ-032 The read address SHALL be pre-issued one cycle ahead so tx_data has no bubble between SYNC and entry 0.

Verification
REQ-033 Write 32 words 0x0000..0x001F with fec=i[0], aux=i[1], tx_ready=1 -> 8x 0xAAAA, then 0x7FFE, then 0x0000..0x001F with matching fec/aux on consecutive cycles, then IDLE.
REQ-034 Hold tx_ready=0 for 20 cycles after fill -> 0xAAAA held for 20 cycles; sync follows 1 cycle after tx_ready rises.
REQ-035 Issue a 33rd write during TRAIN -> pready low until IDLE, then the write is accepted as entry 0 of the next burst.
REQ-036 Read status after 5 writes -> prdata=0x0005 with pready=1; after burst completes -> 0x0000.
REQ-037 Assert presetn=0 at SEND entry 10 -> tx outputs 0 asynchronously; after release, 32 fresh writes produce a clean burst.
REQ-038 Payload word 0x7FFE at entry 3 -> transmitted unchanged, tx_valid=1, burst length still 32.
